// File: rtl/varredura_matriz_if.sv
`default_nettype none
// ============================================================================
// Module      : varredura_matriz_if
// Description : Control/status bundle between the irrigation controller and
//               the 7x5 matrix scan controller.
// Revision    : 1.0 - initial release
// ============================================================================

interface varredura_matriz_if;
    logic       Enable;
    logic       Alterna_Hab;
    logic       Grupo_Fixo;
    logic [2:0] Clock_Linhas;
    logic       img_sel;
    logic       Blank;
    logic       Inicio_Quadro;
    logic       Troca_Img;

    // master: the controller that commands the scan; slave: the scanner itself
    modport master (
        output Enable, Alterna_Hab, Grupo_Fixo,
        input  Clock_Linhas, img_sel, Blank, Inicio_Quadro, Troca_Img
    );

    modport slave (
        input  Enable, Alterna_Hab, Grupo_Fixo,
        output Clock_Linhas, img_sel, Blank, Inicio_Quadro, Troca_Img
    );
endinterface

`default_nettype wire

// File: rtl/varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module      : varredura_matriz
// Description : Row-scan / image-group sequencer for the 7x5 matrix display,
//               with anti-ghosting blank strobe and frame/swap event pulses.
// Revision    : 1.0 - initial release
// ============================================================================

module varredura_matriz #(
    parameter int unsigned DIV_LINHA   = 1000,
    parameter int unsigned BLANK       = 8,
    parameter int unsigned QUADROS_IMG = 50
) (
    input  logic                Clock,
    input  logic                Reset_n,
    varredura_matriz_if.slave   bus
);

    localparam int unsigned c_DIV_W = (DIV_LINHA > 1) ? $clog2(DIV_LINHA) : 1;
    localparam int unsigned c_QDR_W = $clog2(QUADROS_IMG + 1);

    localparam logic [c_DIV_W-1:0] c_BLANK_FIM    = c_DIV_W'(BLANK - 1);
    localparam logic [c_DIV_W-1:0] c_SLOT_FIM     = c_DIV_W'(DIV_LINHA - 1);
    localparam logic [c_QDR_W-1:0] c_QDR_FIM      = c_QDR_W'(QUADROS_IMG - 1);
    localparam logic [2:0]         c_ULTIMA_LINHA = 3'd6;

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        APAGADO = 2'd1,
        ATIVO   = 2'd2
    } estado_t;

    estado_t              estado_q;
    logic [c_DIV_W-1:0]   div_q;
    logic [2:0]           linha_q;
    logic [c_QDR_W-1:0]   quadro_q;
    logic                 img_sel_q;
    logic                 blank_q;
    logic                 inicio_q;
    logic                 troca_q;

    assign bus.Clock_Linhas  = linha_q;
    assign bus.img_sel       = img_sel_q;
    assign bus.Blank         = blank_q;
    assign bus.Inicio_Quadro = inicio_q;
    assign bus.Troca_Img     = troca_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            estado_q  <= PARADO;
            div_q     <= '0;
            linha_q   <= '0;
            quadro_q  <= '0;
            img_sel_q <= 1'b0;
            blank_q   <= 1'b1;
            inicio_q  <= 1'b0;
            troca_q   <= 1'b0;
        end else begin
            inicio_q <= 1'b0;
            troca_q  <= 1'b0;
            if (!bus.Alterna_Hab) begin
                quadro_q <= '0;
            end

            if (estado_q != PARADO && !bus.Enable) begin
                // Stopping discards the partial frame; img_sel is kept.
                estado_q <= PARADO;
                div_q    <= '0;
                linha_q  <= '0;
                quadro_q <= '0;
                blank_q  <= 1'b1;
            end else begin
                case (estado_q)
                    PARADO: begin
                        div_q    <= '0;
                        linha_q  <= '0;
                        quadro_q <= '0;
                        blank_q  <= 1'b1;
                        if (bus.Enable) begin
                            estado_q <= APAGADO;
                            inicio_q <= 1'b1;
                            if (!bus.Alterna_Hab && (bus.Grupo_Fixo != img_sel_q)) begin
                                img_sel_q <= bus.Grupo_Fixo;
                                troca_q   <= 1'b1;
                            end
                        end
                    end

                    APAGADO: begin
                        div_q <= div_q + 1'b1;
                        if (div_q == c_BLANK_FIM) begin
                            estado_q <= ATIVO;
                            blank_q  <= 1'b0;
                        end
                    end

                    ATIVO: begin
                        if (div_q == c_SLOT_FIM) begin
                            estado_q <= APAGADO;
                            blank_q  <= 1'b1;
                            div_q    <= '0;
                            if (linha_q == c_ULTIMA_LINHA) begin
                                linha_q  <= '0;
                                inicio_q <= 1'b1;
                                // Group changes only at a frame boundary.
                                if (bus.Alterna_Hab) begin
                                    if (quadro_q == c_QDR_FIM) begin
                                        quadro_q  <= '0;
                                        img_sel_q <= ~img_sel_q;
                                        troca_q   <= 1'b1;
                                    end else begin
                                        quadro_q <= quadro_q + 1'b1;
                                    end
                                end else if (bus.Grupo_Fixo != img_sel_q) begin
                                    img_sel_q <= bus.Grupo_Fixo;
                                    troca_q   <= 1'b1;
                                end
                            end else begin
                                linha_q <= linha_q + 1'b1;
                            end
                        end else begin
                            div_q <= div_q + 1'b1;
                        end
                    end

                    default: begin
                        estado_q <= PARADO;
                        blank_q  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_varredura_matriz.sv
`default_nettype none
// ============================================================================
// Module      : tb_varredura_matriz
// Description : Scoreboard bench for varredura_matriz (DIV_LINHA=4, BLANK=1,
//               QUADROS_IMG=2): reset, scan, alternation, fixed group, stop.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_varredura_matriz;

    localparam int c_BIG = 1000000;

    typedef struct {
        int         cyc;
        logic [2:0] linha;
        logic       img;
        logic       blank;
        logic       inicio;
        logic       troca;
    } exp_t;

    logic Clock;
    logic Reset_n;
    int   cyc;
    int   n_total;
    int   n_pass;
    exp_t sb[$];
    exp_t q_async[$];
    event probe_ev;

    varredura_matriz_if bus ();

    varredura_matriz #(
        .DIV_LINHA   (4),
        .BLANK       (1),
        .QUADROS_IMG (2)
    ) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input int at,
                         input logic [6:0] act, input logic [6:0] req);
        n_total++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d actual=%b required=%b (linha[2:0],img,blank,inicio,troca)",
                     name, at, act, req);
        end
    endtask

    function automatic logic [6:0] obs();
        return {bus.Clock_Linhas, bus.img_sel, bus.Blank, bus.Inicio_Quadro, bus.Troca_Img};
    endfunction

    function automatic logic [6:0] pack(input exp_t e);
        return {e.linha, e.img, e.blank, e.inicio, e.troca};
    endfunction

    task automatic push_fixed(input int at, input logic [2:0] linha, input logic img,
                              input logic blank, input logic ini, input logic tro);
        exp_t e;
        e.cyc = at; e.linha = linha; e.img = img; e.blank = blank;
        e.inicio = ini; e.troca = tro;
        sb.push_back(e);
    endtask

    // k is the cycle number counted from the edge that leaves PARADO (k=1).
    task automatic push_span(input int base, input int k0, input int k1,
                             input logic img_a, input int k_sw, input logic img_b);
        for (int k = k0; k <= k1; k++) begin
            push_fixed(base + k, 3'(((k - 1) / 4) % 7), (k < k_sw) ? img_a : img_b,
                       ((k - 1) % 4) == 0, ((k - 1) % 28) == 0, k == k_sw);
        end
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) @(negedge Clock);
    endtask

    initial begin : monitor
        exp_t e;
        logic hit;
        forever begin
            @(negedge Clock);
            hit = 1'b0;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                if (e.cyc < cyc) begin
                    check("missed_slot", e.cyc, 7'h7f, pack(e));
                end else begin
                    check("scan", cyc, obs(), pack(e));
                    hit = 1'b1;
                end
            end
            if (!hit) begin
                check("free_pulse", cyc, {5'd0, bus.Inicio_Quadro, bus.Troca_Img}, 7'd0);
            end
        end
    end

    initial begin : async_monitor
        exp_t e;
        forever begin
            @(probe_ev);
            while (q_async.size() > 0) begin
                e = q_async.pop_front();
                check("async_reset", cyc, obs(), pack(e));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int   c0;
        int   c1;
        int   c2;
        exp_t ea;
        n_total = 0;
        n_pass  = 0;
        Reset_n         = 1'b0;
        bus.Enable      = 1'b1;
        bus.Alterna_Hab = 1'b1;
        bus.Grupo_Fixo  = 1'b0;

        // Reset held with Enable=1: outputs stay at reset values.
        @(negedge Clock);
        for (int i = 1; i <= 3; i++) push_fixed(cyc + i, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_to(cyc + 3);

        // Free-running scan with automatic alternation every 2 frames.
        c0 = cyc;
        Reset_n = 1'b1;
        push_span(c0, 1, 56, 1'b0, c_BIG, 1'b0);
        push_span(c0, 57, 112, 1'b0, 57, 1'b1);
        push_span(c0, 113, 120, 1'b1, 113, 1'b0);
        wait_to(c0 + 120);

        // Fixed group: Grupo_Fixo rises in row 3, applied at the next wrap.
        bus.Alterna_Hab = 1'b0;
        push_span(c0, 121, 180, 1'b0, 169, 1'b1);
        wait_to(c0 + 153);
        bus.Grupo_Fixo = 1'b1;
        wait_to(c0 + 180);

        // Stop during row 4 ATIVO, then restart.
        push_span(c0, 181, 186, 1'b1, c_BIG, 1'b1);
        for (int k = 187; k <= 190; k++) push_fixed(c0 + k, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_to(c0 + 186);
        bus.Enable = 1'b0;
        wait_to(c0 + 190);
        bus.Enable = 1'b1;
        c1 = c0 + 190;
        push_span(c1, 1, 22, 1'b1, c_BIG, 1'b1);
        wait_to(c1 + 22);

        // Asynchronous reset pulse between edges during row 5.
        #1 Reset_n = 1'b0;
        #1;
        ea.cyc = cyc; ea.linha = 3'd0; ea.img = 1'b0; ea.blank = 1'b1;
        ea.inicio = 1'b0; ea.troca = 1'b0;
        q_async.push_back(ea);
        -> probe_ev;
        #1 Reset_n = 1'b1;

        // Restart with Grupo_Fixo=1 against img_sel=0: both pulses together.
        c2 = c1 + 22;
        push_span(c2, 1, 30, 1'b0, 1, 1'b1);
        wait_to(c2 + 32);
        check("queue_drained", cyc, 7'(sb.size()), 7'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
